// File: rtl/clock_time_controller.sv
// rtl/clock_time_controller.sv - 1 s prescaler, sec/min/hr chain and set-mode FSM
// Optional alarm comparator enabled by defining CLK_ALARM_EN.
module clock_time_controller #(
    parameter int TICKS_PER_SEC = 100_000_000
) (
    input  logic       clk,
    input  logic       reset_count,
    input  logic       run_en,
    input  logic       btn_mode,
    input  logic       btn_inc,
`ifdef CLK_ALARM_EN
    input  logic [4:0] alarm_hr,
    input  logic [5:0] alarm_min,
    input  logic       alarm_arm,
    output logic       alarm_out,
`endif
    output logic [5:0] sec_out,
    output logic [5:0] min_out,
    output logic [4:0] hr_out,
    output logic [1:0] mode_out,
    output logic       sec_tick
);

    localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;

    logic       counting;
    logic       tick;
    logic       sec_wrap;
    logic       min_wrap;
    logic       hr_wrap;
    logic [5:0] sec_next;
    logic [5:0] min_next;
    logic [4:0] hr_next;

    assign counting = (state == RUN) && run_en;
    assign tick     = counting && (presc == PRE_LAST);
    assign sec_wrap = (sec_out == 6'd59);
    assign min_wrap = (min_out == 6'd59);
    assign hr_wrap  = (hr_out == 5'd23);

    // Whole carry chain resolves combinationally so 23:59:59 -> 00:00:00 lands on one edge.
    always_comb begin
        sec_next = sec_out;
        min_next = min_out;
        hr_next  = hr_out;
        if (tick) begin
            sec_next = sec_wrap ? 6'd0 : sec_out + 6'd1;
            if (sec_wrap) begin
                min_next = min_wrap ? 6'd0 : min_out + 6'd1;
                if (min_wrap) begin
                    hr_next = hr_wrap ? 5'd0 : hr_out + 5'd1;
                end
            end
        end
    end

    assign mode_out = state;

    always_ff @(posedge clk or posedge reset_count) begin
        if (reset_count) begin
            state    <= RUN;
            presc    <= '0;
            sec_out  <= '0;
            min_out  <= '0;
            hr_out   <= '0;
            sec_tick <= 1'b0;
        end else begin
            sec_tick <= tick;
            if (counting) begin
                presc <= tick ? '0 : presc + PRE_ONE;
            end
            sec_out <= sec_next;
            min_out <= min_next;
            hr_out  <= hr_next;
            // Mode takes priority; a coincident increment is dropped.
            if (btn_mode) begin
                case (state)
                    RUN:     state <= SET_HR;
                    SET_HR:  state <= SET_MIN;
                    default: begin
                        state   <= RUN;
                        sec_out <= '0;
                        presc   <= '0;
                    end
                endcase
            end else if (btn_inc) begin
                case (state)
                    SET_HR:  hr_out  <= hr_wrap ? 5'd0 : hr_out + 5'd1;
                    SET_MIN: min_out <= min_wrap ? 6'd0 : min_out + 6'd1;
                    default: ;
                endcase
            end
        end
    end

`ifdef CLK_ALARM_EN
    logic alarm_hit;

    assign alarm_hit = tick && alarm_arm && sec_wrap
                    && (alarm_hr <= 5'd23) && (alarm_min <= 6'd59)
                    && (hr_next == alarm_hr) && (min_next == alarm_min);

    always_ff @(posedge clk or posedge reset_count) begin
        if (reset_count) begin
            alarm_out <= 1'b0;
        end else if (btn_inc || !alarm_arm) begin
            alarm_out <= 1'b0;
        end else if (alarm_hit) begin
            alarm_out <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_clock_time_controller.sv
// tb/tb_clock_time_controller.sv - directed bench with a seconds-of-day reference model
module tb_clock_time_controller;

    localparam int T = 4;

    logic       clk = 1'b0;
    logic       reset_count;
    logic       run_en;
    logic       btn_mode;
    logic       btn_inc;
    logic [5:0] sec_out;
    logic [5:0] min_out;
    logic [4:0] hr_out;
    logic [1:0] mode_out;
    logic       sec_tick;
`ifdef CLK_ALARM_EN
    logic [4:0] alarm_hr;
    logic [5:0] alarm_min;
    logic       alarm_arm;
    logic       alarm_out;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: time held as seconds since midnight.
    int m_tsec;
    int m_phase;
    int m_mode;
    int m_tick;
    int m_alarm;

    clock_time_controller #(.TICKS_PER_SEC(T)) dut (
        .clk        (clk),
        .reset_count(reset_count),
        .run_en     (run_en),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
`ifdef CLK_ALARM_EN
        .alarm_hr   (alarm_hr),
        .alarm_min  (alarm_min),
        .alarm_arm  (alarm_arm),
        .alarm_out  (alarm_out),
`endif
        .sec_out    (sec_out),
        .min_out    (min_out),
        .hr_out     (hr_out),
        .mode_out   (mode_out),
        .sec_tick   (sec_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk or posedge reset_count);
            if (reset_count) begin
                m_tsec = 0; m_phase = 0; m_mode = 0; m_tick = 0; m_alarm = 0;
            end else begin
                m_tick = 0;
                if (m_mode == 0 && run_en) begin
                    if (m_phase == T - 1) begin
                        m_phase = 0;
                        m_tsec  = (m_tsec + 1) % 86400;
                        m_tick  = 1;
                    end else begin
                        m_phase++;
                    end
                end
`ifdef CLK_ALARM_EN
                if (btn_inc || !alarm_arm) m_alarm = 0;
                else if (m_tick == 1 && alarm_hr < 24 && alarm_min < 60
                         && m_tsec == int'(alarm_hr) * 3600 + int'(alarm_min) * 60)
                    m_alarm = 1;
`endif
                if (btn_mode) begin
                    if (m_mode == 2) begin
                        m_tsec  = m_tsec - m_tsec % 60;
                        m_phase = 0;
                    end
                    m_mode = (m_mode + 1) % 3;
                end else if (btn_inc) begin
                    if (m_mode == 1)
                        m_tsec = m_tsec % 3600 + ((m_tsec / 3600 + 1) % 24) * 3600;
                    else if (m_mode == 2)
                        m_tsec = m_tsec - ((m_tsec / 60) % 60) * 60 + (((m_tsec / 60) % 60 + 1) % 60) * 60;
                end
                check("sec", int'(sec_out), m_tsec % 60);
                check("min", int'(min_out), (m_tsec / 60) % 60);
                check("hr", int'(hr_out), m_tsec / 3600);
                check("mode", int'(mode_out), m_mode);
                check("tick", int'(sec_tick), m_tick);
`ifdef CLK_ALARM_EN
                check("alarm", int'(alarm_out), m_alarm);
`endif
            end
        end
    end

    task automatic cycle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic press(input logic mode, input logic inc);
        btn_mode = mode;
        btn_inc  = inc;
        cycle(1);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
    endtask

    task automatic do_reset();
        reset_count = 1'b1;
        btn_mode    = 1'b0;
        btn_inc     = 1'b0;
        cycle(2);
        reset_count = 1'b0;
    endtask

    int ticks;
    int seen;

    initial begin
        reset_count = 1'b1;
        run_en      = 1'b1;
        btn_mode    = 1'b0;
        btn_inc     = 1'b0;
`ifdef CLK_ALARM_EN
        alarm_hr    = 5'd0;
        alarm_min   = 6'd1;
        alarm_arm   = 1'b0;
`endif
        do_reset();
        check("rst_sec", int'(sec_out), 0);
        check("rst_mode", int'(mode_out), 0);
        check("rst_tick", int'(sec_tick), 0);

        // 240 cycles -> 60 ticks, 00:01:00
        ticks = 0;
        repeat (240) begin
            cycle(1);
            ticks += int'(sec_tick);
        end
        check("t1_ticks", ticks, 60);
        check("t1_sec", int'(sec_out), 0);
        check("t1_min", int'(min_out), 1);
        check("t1_hr", int'(hr_out), 0);

        // Set 23:59, then roll over to midnight
        do_reset();
        press(1'b1, 1'b0);
        repeat (23) press(1'b0, 1'b1);
        check("t2_hr23", int'(hr_out), 23);
        press(1'b1, 1'b0);
        repeat (59) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        check("t2_set_mode", int'(mode_out), 0);
        check("t2_set_min", int'(min_out), 59);
        check("t2_set_sec", int'(sec_out), 0);
        cycle(240);
        check("t2_roll_hr", int'(hr_out), 0);
        check("t2_roll_min", int'(min_out), 0);
        check("t2_roll_sec", int'(sec_out), 0);

        // Terminal tick coinciding with RUN->SET_HR, then mode beats inc
        do_reset();
        cycle(3);
        press(1'b1, 1'b0);
        check("t3_tick_sec", int'(sec_out), 1);
        check("t3_tick_mode", int'(mode_out), 1);
        repeat (5) press(1'b0, 1'b1);
        press(1'b1, 1'b1);
        check("t3_both_mode", int'(mode_out), 2);
        check("t3_both_hr", int'(hr_out), 5);
        press(1'b1, 1'b0);
        check("t3_exit_sec", int'(sec_out), 0);

        // Asynchronous reset between edges at 00:00:37
        do_reset();
        cycle(37 * T);
        check("t4_pre_sec", int'(sec_out), 37);
        reset_count = 1'b1;
        #1;
        check("t4_async_sec", int'(sec_out), 0);
        check("t4_async_min", int'(min_out), 0);
        check("t4_async_hr", int'(hr_out), 0);
        check("t4_async_mode", int'(mode_out), 0);
        reset_count = 1'b0;
        cycle(1);

        // run_en hold at 00:00:10
        do_reset();
        cycle(10 * T);
        run_en = 1'b0;
        ticks = 0;
        repeat (100) begin
            cycle(1);
            ticks += int'(sec_tick);
        end
        check("t5_hold_ticks", ticks, 0);
        check("t5_hold_sec", int'(sec_out), 10);
        run_en = 1'b1;
        seen = 0;
        for (int i = 0; i < T && seen == 0; i++) begin
            cycle(1);
            seen = int'(sec_tick);
        end
        check("t5_resume_tick", seen, 1);
        check("t5_resume_sec", int'(sec_out), 11);

`ifdef CLK_ALARM_EN
        alarm_hr  = 5'd0;
        alarm_min = 6'd1;
        alarm_arm = 1'b1;
        do_reset();
        cycle(60 * T);
        check("t6_alarm_set", int'(alarm_out), 1);
        press(1'b0, 1'b1);
        check("t6_alarm_clr", int'(alarm_out), 0);
        alarm_arm = 1'b0;
        do_reset();
        cycle(60 * T + 4);
        check("t6_alarm_disarmed", int'(alarm_out), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
